// File: rtl/rr_arbiter_n_pkg.sv
// Shared types and helpers for the N-input round-robin / fixed-priority arbiter.
//   arb_mode_e : run-time arbitration mode (fixed priority or round-robin)
//   out_state_e: output register occupancy
//   next_idx   : wrapping increment used to advance the round-robin pointer
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Increment idx, wrapping from n-1 back to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Bundle of the arbiter's handshake/bus signals.
//   mode_rr   : 1 = round-robin, 0 = fixed priority
//   in_valid  : per-input request
//   in_data   : packed input data, input i at [i*WIDTH +: WIDTH]
//   in_ready  : per-input accept (at most one set)
//   out_valid : output register holds a word
//   out_data  : registered winning data
//   out_idx   : registered winning input index
//   out_ready : downstream accept
// master = environment side (sources + sink), slave = arbiter side.
interface rr_arbiter_n_if #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32
);
  localparam int IDX_W = $clog2(NUM_IN);

  logic                    mode_rr;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_ready;

  modport master (
    output mode_rr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  mode_rr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/rr_arbiter_n_pick.sv
// Combinational rotating priority picker.
//   req_i   : request vector
//   start_i : index where the ascending search begins (0 = plain priority)
//   grant_o : one-hot winner
//   idx_o   : encoded winner index
//   any_o   : at least one request present
// Requests at or above start_i are placed in the low half of a double-width
// vector and the unmasked copy in the high half; the lowest set bit of that
// vector is the first requester found searching upward from start_i with wrap.
module rr_priority_pick #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  start_i,
  output logic [NUM_IN-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);
  localparam int DBL_W = $clog2(2 * NUM_IN);

  logic [NUM_IN-1:0]   masked_req;
  logic [2*NUM_IN-1:0] dbl_req;
  logic [DBL_W-1:0]    hit_pos;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_mask
    assign masked_req[gi] = req_i[gi] & (IDX_W'(gi) >= start_i);
  end

  assign dbl_req = {req_i, masked_req};

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    hit_pos = '0;
    any_o   = 1'b0;
    for (int i = 2 * NUM_IN - 1; i >= 0; i--) begin
      if (dbl_req[i]) begin
        hit_pos = DBL_W'(i);
        any_o   = 1'b1;
      end
    end
  end

  always_comb begin
    if (hit_pos >= DBL_W'(NUM_IN)) begin
      idx_o = IDX_W'(hit_pos - DBL_W'(NUM_IN));
    end else begin
      idx_o = IDX_W'(hit_pos);
    end
    grant_o = '0;
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-input valid/ready arbiter merging NUM_IN channels into one registered
// output channel tagged with the winning input index.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of rr_arbiter_n_if (mode_rr, in_valid, in_data,
//              in_ready, out_valid, out_data, out_idx, out_ready)
// Modes: fixed priority (lowest index wins) or round-robin where one input
// may win up to MAX_BURST consecutive grants before the pointer moves past it.
module rr_arbiter_n #(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 1
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_n_if.slave bus
);
  import arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  out_state_e        state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0]  last_w_q, last_w_d;

  arb_mode_e         mode;
  logic [IDX_W-1:0]  start_ptr;
  logic [NUM_IN-1:0] pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              can_load;
  logic              grant_en;
  logic [CNT_W-1:0]  cnt_next;

  assign mode      = arb_mode_e'(bus.mode_rr);
  // Fixed priority is the same search anchored at input 0.
  assign start_ptr = (mode == ARB_RR) ? rr_ptr_q : '0;

  rr_priority_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i   (bus.in_valid),
    .start_i (start_ptr),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign can_load = (state_q == OUT_EMPTY) || bus.out_ready;
  // No transfer may be accepted while reset is asserted.
  assign grant_en = can_load && pick_any && !rst;

  assign bus.in_ready  = grant_en ? pick_grant : '0;
  assign bus.out_valid = (state_q == OUT_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

  // Continue a burst only if the same input wins again mid-burst.
  assign cnt_next = ((pick_idx == last_w_q) && (burst_cnt_q != '0))
                    ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    last_w_d    = last_w_q;

    if (grant_en) begin
      state_d    = OUT_FULL;
      out_data_d = bus.in_data[int'(pick_idx) * WIDTH +: WIDTH];
      out_idx_d  = pick_idx;
      if (mode == ARB_RR) begin
        last_w_d = pick_idx;
        if (cnt_next == CNT_W'(MAX_BURST)) begin
          rr_ptr_d    = IDX_W'(next_idx(int'(pick_idx), NUM_IN));
          burst_cnt_d = '0;
        end else begin
          rr_ptr_d    = pick_idx;
          burst_cnt_d = cnt_next;
        end
      end
    end else if ((state_q == OUT_FULL) && bus.out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OUT_EMPTY;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      last_w_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      last_w_q    <= last_w_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  rr_arbiter_n_if #(.NUM_IN(4), .WIDTH(32)) bus_a ();
  rr_arbiter_n_if #(.NUM_IN(4), .WIDTH(32)) bus_b ();

  rr_arbiter_n #(.NUM_IN(4), .WIDTH(32), .MAX_BURST(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  rr_arbiter_n #(.NUM_IN(4), .WIDTH(32), .MAX_BURST(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [1:0]  exp_idx;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[19];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle on dut_a: drive after negedge, check in_ready before the edge,
  // check registered outputs just after the edge.
  task automatic step_a(input string tag, input logic r, input logic m,
                        input logic [3:0] v, input logic o,
                        input logic [3:0] er, input logic eov,
                        input logic [1:0] eidx, input logic [31:0] ed);
    rst_a          = r;
    bus_a.mode_rr  = m;
    bus_a.in_valid = v;
    bus_a.out_ready = o;
    #1;
    chk({tag, " in_ready"}, 32'(bus_a.in_ready), 32'(er));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(bus_a.out_valid), 32'(eov));
    chk({tag, " out_idx"}, 32'(bus_a.out_idx), 32'(eidx));
    chk({tag, " out_data"}, bus_a.out_data, ed);
    $display("txn %s ready=%b valid=%b idx=%0d data=%h", tag, er,
             bus_a.out_valid, bus_a.out_idx, bus_a.out_data);
    @(negedge clk);
  endtask

  task automatic step_b(input string tag, input logic r, input logic [3:0] v,
                        input logic [3:0] er, input logic eov, input logic [1:0] eidx);
    rst_b          = r;
    bus_b.in_valid = v;
    #1;
    chk({tag, " in_ready"}, 32'(bus_b.in_ready), 32'(er));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(bus_b.out_valid), 32'(eov));
    chk({tag, " out_idx"}, 32'(bus_b.out_idx), 32'(eidx));
    $display("txn %s ready=%b valid=%b idx=%0d", tag, er, bus_b.out_valid, bus_b.out_idx);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic r, input logic m, input logic [3:0] v,
                              input logic o, input logic [3:0] er, input logic eov,
                              input logic [1:0] eidx, input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.mode = m; t.valid = v; t.ordy = o;
    t.exp_ready = er; t.exp_ov = eov; t.exp_idx = eidx; t.exp_data = ed;
    return t;
  endfunction

  initial begin
    // dut_a: reset, round-robin sweep, mode switch, fixed priority,
    // drain, backpressure hold, reset while FULL, fixed-mode first grant.
    vecs[0]  = mk(1, 1, 4'b1111, 1, 4'b0000, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 4'b1111, 1, 4'b0000, 0, 0, 32'h0);
    vecs[2]  = mk(0, 1, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0);
    vecs[3]  = mk(0, 1, 4'b1111, 1, 4'b0010, 1, 1, 32'hA1);
    vecs[4]  = mk(0, 1, 4'b1111, 1, 4'b0100, 1, 2, 32'hA2);
    vecs[5]  = mk(0, 1, 4'b1111, 1, 4'b1000, 1, 3, 32'hA3);
    vecs[6]  = mk(0, 1, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0);
    vecs[7]  = mk(0, 1, 4'b1111, 1, 4'b0010, 1, 1, 32'hA1);
    vecs[8]  = mk(0, 0, 4'b1110, 1, 4'b0010, 1, 1, 32'hA1);
    vecs[9]  = mk(0, 0, 4'b1010, 1, 4'b0010, 1, 1, 32'hA1);
    vecs[10] = mk(0, 0, 4'b1010, 1, 4'b0010, 1, 1, 32'hA1);
    vecs[11] = mk(0, 0, 4'b1010, 1, 4'b0010, 1, 1, 32'hA1);
    vecs[12] = mk(0, 1, 4'b1010, 1, 4'b1000, 1, 3, 32'hA3);
    vecs[13] = mk(0, 1, 4'b0000, 1, 4'b0000, 0, 3, 32'hA3);
    vecs[14] = mk(0, 1, 4'b0100, 0, 4'b0100, 1, 2, 32'hA2);
    vecs[15] = mk(0, 1, 4'b0001, 0, 4'b0000, 1, 2, 32'hA2);
    vecs[16] = mk(0, 1, 4'b0001, 1, 4'b0001, 1, 0, 32'hA0);
    vecs[17] = mk(1, 1, 4'b1111, 0, 4'b0000, 0, 0, 32'h0);
    vecs[18] = mk(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0);

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.mode_rr = 1'b1;
    bus_a.in_valid = '0;
    bus_a.out_ready = 1'b1;
    bus_a.in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus_b.mode_rr = 1'b1;
    bus_b.in_valid = '0;
    bus_b.out_ready = 1'b1;
    bus_b.in_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      step_a($sformatf("vec%0d", i), vecs[i].rst, vecs[i].mode, vecs[i].valid,
             vecs[i].ordy, vecs[i].exp_ready, vecs[i].exp_ov, vecs[i].exp_idx,
             vecs[i].exp_data);
    end

    // Backpressure: hold idx 2 / 0xBEEF for 5 stalled cycles, then drain and
    // load in the same edge.
    step_a("bp_rst", 1, 0, 4'b0000, 1, 4'b0000, 0, 0, 32'h0);
    bus_a.in_data = {32'h3333, 32'hBEEF, 32'h1111, 32'h1234};
    step_a("bp_load", 0, 0, 4'b0100, 1, 4'b0100, 1, 2, 32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      step_a($sformatf("bp_hold%0d", i), 0, 0, 4'b1111, 0, 4'b0000, 1, 2, 32'hBEEF);
    end
    step_a("bp_release", 0, 0, 4'b0001, 1, 4'b0001, 1, 0, 32'h1234);

    // Burst on dut_b (MAX_BURST=3): inputs 0 and 2 alternate in runs of three.
    step_b("burst_rst0", 1, 4'b0101, 4'b0000, 0, 0);
    step_b("burst_rst1", 1, 4'b0101, 4'b0000, 0, 0);
    begin
      logic [1:0] seq [9];
      seq = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
      for (int i = 0; i < 9; i++) begin
        step_b($sformatf("burst%0d", i), 0, 4'b0101, 4'(1 << seq[i]), 1, seq[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
